// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM measurement block and the beat scheduler.
package bpm_pkg;

    localparam logic [7:0] BPM_MIN     = 8'd40;
    localparam logic [7:0] BPM_MAX     = 8'd255;
    localparam logic [7:0] BPM_DEFAULT = 8'd240;

    localparam int unsigned DIV_W  = 32;
    localparam int unsigned DVSR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN
    } sched_state_t;

    // Measurement-block operating modes
    typedef enum logic [1:0] {
        MODE_TAP  = 2'd0,
        MODE_AUTO = 2'd1,
        MODE_HOLD = 2'd2
    } bpm_mode_t;

    // Lower clamp only; the upper bound is the 8-bit range itself
    function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm);
        return (bpm < BPM_MIN) ? BPM_MIN : bpm;
    endfunction

endpackage

// File: rtl/beat_scheduler_divider.sv
// 32/10 unsigned restoring divider, one quotient bit per cycle.
// start loads the operands; done pulses for one cycle after the 32nd bit.
module serial_divider
    import bpm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [DVSR_W-1:0] divisor,
    output logic [DIV_W-1:0]  quotient,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DIV_W);

    logic [DVSR_W-1:0] dvsr_q;
    logic [DVSR_W:0]   rem_q;
    logic [DVSR_W:0]   shifted;
    logic [DVSR_W:0]   diff;
    logic [CNT_W-1:0]  count_q;
    logic              running_q;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem_q[DVSR_W-1:0], quotient[DIV_W-1]};
        diff    = shifted - {1'b0, dvsr_q};
    end

    // Operand load and one restoring step per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                dvsr_q    <= divisor;
                rem_q     <= '0;
                count_q   <= '0;
                running_q <= 1'b1;
            end else if (running_q) begin
                if (shifted >= {1'b0, dvsr_q}) begin
                    rem_q    <= diff;
                    quotient <= {quotient[DIV_W-2:0], 1'b1};
                end else begin
                    rem_q    <= shifted;
                    quotient <= {quotient[DIV_W-2:0], 1'b0};
                end
                count_q <= count_q + CNT_W'(1);
                if (count_q == CNT_W'(DIV_W - 1)) begin
                    running_q <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// Phase-stable metronome: converts clamped BPM into a tick period and emits
// tick/beat/bar strobes. Tempo changes take effect only on beat boundaries.
module beat_scheduler
    import bpm_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 200_000_000,
    parameter int unsigned SUBDIV        = 4,
    parameter int unsigned BEATS_PER_BAR = 4
) (
    input  logic                             clk_camera_in,
    input  logic                             rst_n_in,
    input  logic [7:0]                       bpm_in,
    input  logic                             run_in,
    output logic                             tick_out,
    output logic                             beat_out,
    output logic                             bar_out,
    output logic [$clog2(SUBDIV)-1:0]        sub_idx_out,
    output logic [$clog2(BEATS_PER_BAR)-1:0] beat_idx_out,
    output logic [7:0]                       active_bpm_out,
    output logic [31:0]                      period_out,
    output logic                             busy_out
);

    localparam int unsigned SUB_W  = $clog2(SUBDIV);
    localparam int unsigned BEAT_W = $clog2(BEATS_PER_BAR);
    localparam logic [63:0] NUM_W  = 64'(CLK_HZ) * 64'd60 / 64'(SUBDIV);
    localparam logic [DIV_W-1:0] NUM = NUM_W[DIV_W-1:0];

    sched_state_t      state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       period_q, period_d;
    logic [7:0]        active_q, active_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [BEAT_W-1:0] bidx_q, bidx_d;
    logic              tick_q, tick_d;
    logic              beat_str_q, beat_str_d;
    logic              bar_q, bar_d;
    logic              start_q, start_d;
    logic [7:0]        div_bpm_q, div_bpm_d;
    logic              div_run_q, div_run_d;
    logic              pend_valid_q, pend_valid_d;
    logic [31:0]       pend_period_q, pend_period_d;
    logic [7:0]        pend_bpm_q, pend_bpm_d;

    logic [7:0]        bpm_c;
    logic              abort;
    logic              div_reset;
    logic              div_done;
    logic              div_idle;
    logic [DIV_W-1:0]  quotient;
    logic [DVSR_W-1:0] divisor;
    logic              wrap;
    logic              sub_last;
    logic              bidx_last;
    logic [SUB_W-1:0]  sub_n;
    logic [BEAT_W-1:0] bidx_n;
    logic              eff_valid;
    logic [31:0]       eff_period;
    logic [7:0]        eff_bpm;
    logic [7:0]        ref_bpm;

    assign bpm_c     = clamp_bpm(bpm_in);
    assign abort     = (state_q != IDLE) && !run_in;
    assign div_reset = !rst_n_in || abort;
    assign divisor   = DVSR_W'(32'(div_bpm_q) * SUBDIV);
    // The done cycle already counts as idle so a follow-up division starts next cycle
    assign div_idle  = !start_q && (!div_run_q || div_done);
    assign wrap      = (cnt_q == period_q - 32'd1);
    assign sub_last  = (sub_q == SUB_W'(SUBDIV - 1));
    assign bidx_last = (bidx_q == BEAT_W'(BEATS_PER_BAR - 1));
    assign sub_n     = sub_last ? '0 : sub_q + SUB_W'(1);
    assign bidx_n    = sub_last ? (bidx_last ? '0 : bidx_q + BEAT_W'(1)) : bidx_q;

    serial_divider u_div (
        .clk      (clk_camera_in),
        .reset    (div_reset),
        .start    (start_q),
        .dividend (NUM),
        .divisor  (divisor),
        .quotient (quotient),
        .done     (div_done)
    );

    // Next-state, counter, index, pending-tempo and strobe logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        active_d      = active_q;
        sub_d         = sub_q;
        bidx_d        = bidx_q;
        tick_d        = 1'b0;
        beat_str_d    = 1'b0;
        bar_d         = 1'b0;
        start_d       = 1'b0;
        div_bpm_d     = div_bpm_q;
        div_run_d     = div_run_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_bpm_d    = pend_bpm_q;
        eff_valid     = 1'b0;
        eff_period    = '0;
        eff_bpm       = '0;
        ref_bpm       = active_q;

        if (start_q) begin
            div_run_d = 1'b1;
        end else if (div_done) begin
            div_run_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d        = '0;
                sub_d        = '0;
                bidx_d       = '0;
                pend_valid_d = 1'b0;
                if (run_in) begin
                    start_d   = 1'b1;
                    div_bpm_d = bpm_c;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (!run_in) begin
                    state_d      = IDLE;
                    div_run_d    = 1'b0;
                    cnt_d        = '0;
                    sub_d        = '0;
                    bidx_d       = '0;
                    pend_valid_d = 1'b0;
                end else if (div_done) begin
                    period_d   = quotient;
                    active_d   = div_bpm_q;
                    cnt_d      = '0;
                    sub_d      = '0;
                    bidx_d     = '0;
                    tick_d     = 1'b1;
                    beat_str_d = 1'b1;
                    bar_d      = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!run_in) begin
                    state_d      = IDLE;
                    div_run_d    = 1'b0;
                    cnt_d        = '0;
                    sub_d        = '0;
                    bidx_d       = '0;
                    pend_valid_d = 1'b0;
                end else begin
                    // A result arriving on the wrap cycle itself is applied directly
                    eff_valid  = div_done || pend_valid_q;
                    eff_period = div_done ? quotient : pend_period_q;
                    eff_bpm    = div_done ? div_bpm_q : pend_bpm_q;
                    if (div_done) begin
                        pend_valid_d  = 1'b1;
                        pend_period_d = quotient;
                        pend_bpm_d    = div_bpm_q;
                    end
                    if (wrap) begin
                        cnt_d      = '0;
                        sub_d      = sub_n;
                        bidx_d     = bidx_n;
                        tick_d     = 1'b1;
                        beat_str_d = (sub_n == '0);
                        bar_d      = (sub_n == '0) && (bidx_n == '0);
                        if (sub_last && eff_valid) begin
                            period_d     = eff_period;
                            active_d     = eff_bpm;
                            pend_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    // Compare against the newest tempo already divided or in hand
                    ref_bpm = div_done ? div_bpm_q : (pend_valid_q ? pend_bpm_q : active_q);
                    if (div_idle && (bpm_c != ref_bpm)) begin
                        start_d   = 1'b1;
                        div_bpm_d = bpm_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_camera_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            active_q      <= '0;
            sub_q         <= '0;
            bidx_q        <= '0;
            tick_q        <= 1'b0;
            beat_str_q    <= 1'b0;
            bar_q         <= 1'b0;
            start_q       <= 1'b0;
            div_bpm_q     <= '0;
            div_run_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_bpm_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            active_q      <= active_d;
            sub_q         <= sub_d;
            bidx_q        <= bidx_d;
            tick_q        <= tick_d;
            beat_str_q    <= beat_str_d;
            bar_q         <= bar_d;
            start_q       <= start_d;
            div_bpm_q     <= div_bpm_d;
            div_run_q     <= div_run_d;
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            pend_bpm_q    <= pend_bpm_d;
        end
    end

    assign tick_out       = tick_q;
    assign beat_out       = beat_str_q;
    assign bar_out        = bar_q;
    assign sub_idx_out    = sub_q;
    assign beat_idx_out   = bidx_q;
    assign active_bpm_out = active_q;
    assign period_out     = period_q;
    assign busy_out       = start_q || (div_run_q && !div_done);

endmodule

// File: tb/tb_beat_scheduler.sv
// Scoreboard bench for beat_scheduler at CLK_HZ=4000, SUBDIV=4, BEATS_PER_BAR=4.
module tb_beat_scheduler;

    localparam int unsigned SUBDIV = 4;
    localparam int unsigned BPB    = 4;

    typedef struct {
        int unsigned cyc;
        int unsigned sub;
        int unsigned beat;
        int unsigned per;
    } tick_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  bpm;
    logic        tick, beat, bar, busy;
    logic [1:0]  sub, beat_idx;
    logic [7:0]  act;
    logic [31:0] per;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned m_sub = 0;
    int unsigned m_beat = 0;
    tick_t       exp_q[$];

    beat_scheduler #(
        .CLK_HZ        (4000),
        .SUBDIV        (SUBDIV),
        .BEATS_PER_BAR (BPB)
    ) dut (
        .clk_camera_in  (clk),
        .rst_n_in       (rst_n),
        .bpm_in         (bpm),
        .run_in         (run),
        .tick_out       (tick),
        .beat_out       (beat),
        .bar_out        (bar),
        .sub_idx_out    (sub),
        .beat_idx_out   (beat_idx),
        .active_bpm_out (act),
        .period_out     (per),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_tick(input int unsigned c, input int unsigned p);
        tick_t e;
        e.cyc  = c;
        e.sub  = m_sub;
        e.beat = m_beat;
        e.per  = p;
        exp_q.push_back(e);
        m_sub = (m_sub + 1) % SUBDIV;
        if (m_sub == 0) m_beat = (m_beat + 1) % BPB;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input string tag, input int unsigned limit);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_beat"}, beat, 0);
        check({tag, "_bar"}, bar, 0);
        check({tag, "_sub"}, sub, 0);
        check({tag, "_beat_idx"}, beat_idx, 0);
        check({tag, "_active"}, act, 0);
        check({tag, "_period"}, per, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Output monitor: each tick pops the scoreboard; overdue entries count as missed
    always @(negedge clk) begin : mon
        tick_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("tick_missing", cyc, e.cyc);
        end
        if (tick) begin
            if (exp_q.size() == 0) begin
                check("spurious_tick", tick, 0);
            end else begin
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_sub", sub, e.sub);
                check("tick_beat_idx", beat_idx, e.beat);
                check("tick_beat", beat, e.sub == 0);
                check("tick_bar", bar, (e.sub == 0) && (e.beat == 0));
                check("tick_period", per, e.per);
            end
        end else if (beat || bar) begin
            check("stray_strobe", beat | bar, 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned n0, t0, t3, t7, t9, low, n;
        rst_n = 1'b0;
        run   = 1'b0;
        bpm   = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Start at 240 BPM, then move to 120 on the second tick of beat 1
        bpm = 8'd240;
        run = 1'b1;
        n0  = cyc + 1;
        t0  = n0 + 34;
        m_sub  = 0;
        m_beat = 0;
        for (int k = 0; k < 8; k++) push_tick(t0 + 62 * k, 62);
        wait_until(n0 + 2);
        check("busy_start", busy, 1);
        wait_until(t0 + 62 * 5);
        bpm = 8'd120;
        t7  = t0 + 62 * 7;
        t9  = t7 + 62 + 125;
        push_tick(t7 + 62, 125);
        push_tick(t9, 125);
        drain("drain_change", 600);
        check("period_120", per, 125);
        check("active_120", act, 120);

        // Drop run mid-bar
        wait_until(t9 + 10);
        check("sub_before_drop", sub, 1);
        check("beat_idx_before_drop", beat_idx, 2);
        run = 1'b0;
        @(negedge clk);
        check("drop_tick", tick, 0);
        check("drop_beat", beat, 0);
        check("drop_bar", bar, 0);
        check("drop_sub", sub, 0);
        check("drop_beat_idx", beat_idx, 0);
        check("drop_busy", busy, 0);
        check("drop_period_kept", per, 125);
        check("drop_active_kept", act, 120);

        // Restart below the clamp
        repeat (4) @(negedge clk);
        bpm = 8'd10;
        run = 1'b1;
        n0  = cyc + 1;
        t0  = n0 + 34;
        m_sub  = 0;
        m_beat = 0;
        for (int k = 0; k < 4; k++) push_tick(t0 + 375 * k, 375);
        wait_until(t0 + 375);
        check("active_clamped", act, 40);
        check("period_clamped", per, 375);

        // 240 -> 120 -> 60 while the first division runs
        bpm = 8'd240;
        repeat (4) @(negedge clk);
        bpm = 8'd120;
        repeat (4) @(negedge clk);
        bpm = 8'd60;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        low = 0;
        while (!busy && low < 50) begin
            low++;
            @(negedge clk);
        end
        check("busy_gap", low, 1);
        t3 = t0 + 3 * 375;
        push_tick(t3 + 375, 250);
        push_tick(t3 + 625, 250);
        push_tick(t3 + 875, 250);
        drain("drain_chain", 3000);
        check("period_60", per, 250);
        check("active_60", act, 60);

        // Reset during CALC
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_calc", busy, 1);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check_all_zero("calc_reset");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("no_late_period", per, 0);
        check("no_late_active", act, 0);
        check("no_late_busy", busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beat_scheduler.md
# beat_scheduler

Turns the tempo from the BPM measurement block into a phase-stable metronome for the rest of the camera-clock domain. It converts the clamped BPM into a subdivision tick period with a serial divider. It emits tick, beat and bar strobes with running indices. Tempo changes are applied only on beat boundaries, so downstream note sequencers never see a partial beat.

## Interface
Parameters:
- CLK_HZ, 200_000_000: camera-clock frequency. CLK_HZ*60 must be divisible by SUBDIV.
- SUBDIV, 4: ticks per beat. Must be a power of two, ≥2.
- BEATS_PER_BAR, 4: beats per bar, ≥2.

Ports:
- clk_camera_in  in  1  sole clock.
- rst_n_in  in  1  reset; synchronous, active-low.
- bpm_in  in  8  tempo from the BPM block. Unsigned, may change on any cycle.
- run_in  in  1  level. High means the metronome runs; low means it stops and clears.
- tick_out  out  1  one-cycle strobe on every subdivision tick.
- beat_out  out  1  one-cycle strobe on ticks where the subdivision index is 0.
- bar_out  out  1  one-cycle strobe on ticks where the subdivision index and the beat index are both 0.
- sub_idx_out  out  $clog2(SUBDIV)  subdivision index of the current tick.
- beat_idx_out  out  $clog2(BEATS_PER_BAR)  beat index within the bar.
- active_bpm_out  out  8  clamped BPM of the period currently in use.
- period_out  out  32  cycles per tick currently in use.
- busy_out  out  1  high while the divider is running.

## Operation
- Clamp: bpm_c = max(BPM_MIN=40, bpm_in). The upper bound is 255 by width.
- Period: P = floor(NUM / (bpm_c*SUBDIV)), where NUM = CLK_HZ*60/SUBDIV as a 32-bit constant.
  - The divisor is 10 bits wide.
  - At default parameters, P = 3_125_000 for bpm 240 and 18_750_000 for bpm 40.
- States: IDLE, CALC, RUN.
- IDLE:
  - All strobes are 0 and the indices and tick counter are held at 0.
  - If run_in is 1, latch bpm_c, start the divider and go to CALC.
- CALC:
  - Wait for the divider's done pulse.
  - On done: load period_out and active_bpm_out, clear the counter and indices, go to RUN.
- RUN:
  - Counter cnt runs 0..P-1 and wraps to 0.
  - tick_out=1 on every cycle where cnt==0. beat_out and bar_out qualify as defined above.
  - sub_idx_out advances on the cycle after each tick and wraps at SUBDIV-1. When it wraps, beat_idx_out advances and wraps at BEATS_PER_BAR-1.
  - The first RUN cycle is a downbeat: tick, beat and bar all assert with both indices 0.
- Tempo change in RUN:
  - If bpm_c ≠ active_bpm_out and the divider is idle, start a background division with bpm_c and keep the old period.
  - A completed result is held as pending. It loads into period_out and active_bpm_out on the cycle cnt wraps with sub_idx_out==SUBDIV-1, so the next tick is a beat on the new period.
  - A newer completed result overwrites the pending one.
  - The divider is never restarted mid-division. After done, if bpm_c still differs from the value divided, the next division starts the following cycle.
- run_in=0 in CALC or RUN:
  - Go to IDLE next cycle and abort the divider.
  - Clear the pending result, counter and indices; strobes go to 0.
  - period_out and active_bpm_out keep their last values.
- Reset: all outputs 0, state IDLE, divider idle, pending cleared.

## Timing
- The divider takes 32 cycles, 1 quotient bit per cycle. done is a one-cycle pulse 33 cycles after the start cycle.
- IDLE to first tick: run_in sampled high at edge N. The divider starts at N+1, done at N+33, and tick_out asserts in cycle N+34.
- In RUN the tick spacing is exactly P cycles, with no jitter and no gap at a tempo switch.
  - The beat before the switch ends on the old P.
  - The next beat starts P_new cycles later.
- Strobes and indices are registered outputs, and all three strobes go high in the same cycle.
- Reset wins over every other event. Reset during CALC discards the division.

## Structure
- Package bpm_pkg holds:
  - BPM_MIN=40, BPM_MAX=255;
  - the sched_state_t enum {IDLE, CALC, RUN};
  - DIV_W=32;
  - shared with the BPM measurement block: its mode encodings and default bpm 240.
- Sub-module serial_divider holds the 32/10 unsigned restoring divider.
  - Ports: clk, reset, start, dividend, divisor, quotient, done.
  - The scheduler treats it as opaque.

## Test plan
Run all scenarios with CLK_HZ=4000, SUBDIV=4, BEATS_PER_BAR=4, so NUM=60000.
- Reset, then run_in=1 with bpm_in=240:
  - busy_out goes high.
  - The first tick is 34 cycles after run_in is sampled, with tick/beat/bar all asserted.
  - period_out=62 and active_bpm_out=240.
  - Ticks then repeat every 62 cycles.
- bpm_in=10: active_bpm_out=40, period_out=375.
- Change bpm_in from 240 to 120 on tick 1 of the beat:
  - Ticks 2–3 keep 62-cycle spacing.
  - The next beat tick comes 62 cycles after tick 3, then spacing becomes 125.
  - beat_idx_out is continuous across the change.
- Change bpm_in 240→120→60 within a single division:
  - The second division starts the cycle after the first done.
  - Final period_out=250, applied at a beat boundary.
- Drop run_in mid-bar, then raise it again:
  - Strobes are 0 the next cycle and the indices clear.
  - On restart the first tick is a bar downbeat 34 cycles later.
- Assert rst_n_in=0 during CALC: all outputs are 0 next cycle and no late period load occurs.
